// File: rtl/instruction_encoder_pkg.sv
// Shared constants for the instruction encoder: ALU control codes, data-processing
// opcodes, condition codes and the load-sequencer state enumeration.
package instruction_encoder_pkg;

    localparam logic [10:0] ALU_ADD = 11'd0;
    localparam logic [10:0] ALU_SUB = 11'd2;
    localparam logic [10:0] ALU_AND = 11'd3;
    localparam logic [10:0] ALU_ORR = 11'd4;
    localparam logic [10:0] ALU_EOR = 11'd5;
    localparam logic [10:0] ALU_MOV = 11'd6;
    localparam logic [10:0] ALU_MVN = 11'd7;
    localparam logic [10:0] ALU_CMP = 11'd8;
    localparam logic [10:0] ALU_TST = 11'd9;
    localparam logic [10:0] ALU_TEQ = 11'd10;
    localparam logic [10:0] ALU_BIC = 11'd11;
    localparam logic [10:0] ALU_B   = 11'd31;
    localparam logic [10:0] ALU_BL  = 11'd32;
    localparam logic [10:0] ALU_LDR = 11'd41;
    localparam logic [10:0] ALU_STR = 11'd42;

    localparam logic [3:0] DP_AND = 4'b0000;
    localparam logic [3:0] DP_EOR = 4'b0001;
    localparam logic [3:0] DP_SUB = 4'b0010;
    localparam logic [3:0] DP_ADD = 4'b0100;
    localparam logic [3:0] DP_TST = 4'b1000;
    localparam logic [3:0] DP_TEQ = 4'b1001;
    localparam logic [3:0] DP_CMP = 4'b1010;
    localparam logic [3:0] DP_ORR = 4'b1100;
    localparam logic [3:0] DP_MOV = 4'b1101;
    localparam logic [3:0] DP_BIC = 4'b1110;
    localparam logic [3:0] DP_MVN = 4'b1111;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// Combinational packing of request fields into a 32-bit instruction word,
// flagging any ALU control code the encoder does not support.
module instr_pack
    import instruction_encoder_pkg::*;
(
    input  logic [10:0] op,
    input  logic [3:0]  cond,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [3:0]  rotate,
    input  logic        s,
    input  logic        imm_en,
    input  logic [7:0]  shift,
    input  logic [7:0]  imm8,
    input  logic [23:0] br_offset,
    input  logic [11:0] dt_offset,
    output logic [31:0] word,
    output logic        illegal
);

    logic        dp;
    logic [3:0]  opcode;
    logic        s_eff;
    logic [3:0]  rn_eff;
    logic [3:0]  rd_eff;
    logic [11:0] op2;

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        dp      = 1'b0;
        opcode  = 4'h0;
        s_eff   = s;
        rn_eff  = rn;
        rd_eff  = rd;
        op2     = imm_en ? {rotate, imm8} : {shift, rm};

        case (op)
            ALU_ADD: begin dp = 1'b1; opcode = DP_ADD; end
            ALU_SUB: begin dp = 1'b1; opcode = DP_SUB; end
            ALU_AND: begin dp = 1'b1; opcode = DP_AND; end
            ALU_ORR: begin dp = 1'b1; opcode = DP_ORR; end
            ALU_EOR: begin dp = 1'b1; opcode = DP_EOR; end
            ALU_BIC: begin dp = 1'b1; opcode = DP_BIC; end
            ALU_MOV: begin dp = 1'b1; opcode = DP_MOV; rn_eff = 4'h0; end
            ALU_MVN: begin dp = 1'b1; opcode = DP_MVN; rn_eff = 4'h0; end
            // Compare/test forms only update flags, so S is forced and rd is zeroed.
            ALU_CMP: begin dp = 1'b1; opcode = DP_CMP; s_eff = 1'b1; rd_eff = 4'h0; end
            ALU_TST: begin dp = 1'b1; opcode = DP_TST; s_eff = 1'b1; rd_eff = 4'h0; end
            ALU_TEQ: begin dp = 1'b1; opcode = DP_TEQ; s_eff = 1'b1; rd_eff = 4'h0; end
            ALU_B:   word = {cond, 3'b101, 1'b0, br_offset};
            ALU_BL:  word = {cond, 3'b101, 1'b1, br_offset};
            ALU_LDR: word = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rn, rd, dt_offset};
            ALU_STR: word = {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rn, rd, dt_offset};
            default: illegal = 1'b1;
        endcase

        if (dp) begin
            word = {cond, 2'b00, imm_en, opcode, s_eff, rn_eff, rd_eff, op2};
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Program-load sequencer: accepts instruction requests, encodes them and writes
// them to consecutive instruction-memory addresses through a one-deep output register.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [10:0]       req_op,
    input  logic [3:0]        req_cond,
    input  logic [3:0]        req_rn,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rm,
    input  logic [3:0]        req_rotate,
    input  logic              req_s,
    input  logic              req_imm_en,
    input  logic [7:0]        req_shift,
    input  logic [7:0]        req_imm8,
    input  logic [23:0]       req_br_offset,
    input  logic [11:0]       req_dt_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output state_e            dbg_state
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_e      state;
    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        accept;
    logic        out_fire;

    instr_pack u_pack (
        .op        (req_op),
        .cond      (req_cond),
        .rn        (req_rn),
        .rd        (req_rd),
        .rm        (req_rm),
        .rotate    (req_rotate),
        .s         (req_s),
        .imm_en    (req_imm_en),
        .shift     (req_shift),
        .imm8      (req_imm8),
        .br_offset (req_br_offset),
        .dt_offset (req_dt_offset),
        .word      (pack_word),
        .illegal   (pack_illegal)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // sender holds valid and payload stable until then. req_ready depends on
    // out_ready so a drain and a refill can share one cycle.
    assign req_ready = (state == ST_LOAD) && (!out_valid || out_ready);
    assign accept    = req_valid && req_ready;
    assign out_fire  = out_valid && out_ready;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_addr    <= '0;
            err_illegal <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wrapped     <= 1'b0;
        end else begin
            err_illegal <= 1'b0;

            if (out_fire) begin
                out_valid <= 1'b0;
                out_addr  <= out_addr + ADDR_ONE;
                if (&out_addr) begin
                    wrapped <= 1'b1;
                end
            end

            if (accept) begin
                if (pack_illegal) begin
                    err_illegal <= 1'b1;
                end else begin
                    out_valid <= 1'b1;
                    out_instr <= pack_word;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        out_addr <= '0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        wrapped  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept && req_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: a field-level encoding model feeds an
// expected-word queue that a per-cycle compare process drains.
module tb_instruction_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [10:0] op;
        logic [3:0]  cond;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [3:0]  rotate;
        logic        s;
        logic        imm_en;
        logic [7:0]  shift;
        logic [7:0]  imm8;
        logic [23:0] br;
        logic [11:0] dt;
    } req_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          req_valid;
    logic          req_ready;
    logic          req_last;
    logic [10:0]   req_op;
    logic [3:0]    req_cond;
    logic [3:0]    req_rn;
    logic [3:0]    req_rd;
    logic [3:0]    req_rm;
    logic [3:0]    req_rotate;
    logic          req_s;
    logic          req_imm_en;
    logic [7:0]    req_shift;
    logic [7:0]    req_imm8;
    logic [23:0]   req_br_offset;
    logic [11:0]   req_dt_offset;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err_illegal;
    logic          busy;
    logic          done;
    logic          wrapped;
    logic [1:0]    dbg_state;

    instruction_encoder #(.ADDR_W(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_last      (req_last),
        .req_op        (req_op),
        .req_cond      (req_cond),
        .req_rn        (req_rn),
        .req_rd        (req_rd),
        .req_rm        (req_rm),
        .req_rotate    (req_rotate),
        .req_s         (req_s),
        .req_imm_en    (req_imm_en),
        .req_shift     (req_shift),
        .req_imm8      (req_imm8),
        .req_br_offset (req_br_offset),
        .req_dt_offset (req_dt_offset),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_addr      (out_addr),
        .err_illegal   (err_illegal),
        .busy          (busy),
        .done          (done),
        .wrapped       (wrapped),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          vectors;
    int          miscompares;
    logic [31:0] exp_q[$];
    int          model_addr;
    bit          exp_err;
    bit          stall_prev;
    logic [31:0] prev_instr;
    logic [AW-1:0] prev_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Encoding model written from the instruction-format rules: {legal, word}.
    function automatic logic [32:0] model(input req_t r);
        logic [3:0]  opc;
        logic [11:0] op2;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        opc = 4'h0;
        s   = r.s;
        rn  = r.rn;
        rd  = r.rd;
        op2 = r.imm_en ? {r.rotate, r.imm8} : {r.shift, r.rm};
        case (r.op)
            11'd0:  opc = 4'b0100;
            11'd2:  opc = 4'b0010;
            11'd3:  opc = 4'b0000;
            11'd4:  opc = 4'b1100;
            11'd5:  opc = 4'b0001;
            11'd6:  opc = 4'b1101;
            11'd7:  opc = 4'b1111;
            11'd8:  opc = 4'b1010;
            11'd9:  opc = 4'b1000;
            11'd10: opc = 4'b1001;
            11'd11: opc = 4'b1110;
            11'd31: return {1'b1, r.cond, 4'b1010, r.br};
            11'd32: return {1'b1, r.cond, 4'b1011, r.br};
            11'd41: return {1'b1, r.cond, 8'h59, r.rn, r.rd, r.dt};
            11'd42: return {1'b1, r.cond, 8'h58, r.rn, r.rd, r.dt};
            default: return 33'h0;
        endcase
        if (r.op == 11'd8 || r.op == 11'd9 || r.op == 11'd10) begin
            s  = 1'b1;
            rd = 4'h0;
        end
        if (r.op == 11'd6 || r.op == 11'd7) rn = 4'h0;
        return {1'b1, r.cond, 2'b00, r.imm_en, opc, s, rn, rd, op2};
    endfunction

    function automatic req_t mk_dp(input logic [10:0] op, input logic [3:0] cond,
                                   input logic [3:0] rd, input logic [3:0] rn,
                                   input logic [3:0] rm, input logic s,
                                   input logic imm_en, input logic [7:0] imm8);
        req_t r;
        r        = '0;
        r.op     = op;
        r.cond   = cond;
        r.rd     = rd;
        r.rn     = rn;
        r.rm     = rm;
        r.s      = s;
        r.imm_en = imm_en;
        r.imm8   = imm8;
        return r;
    endfunction

    function automatic req_t mk_br(input logic [10:0] op, input logic [23:0] off);
        req_t r;
        r      = '0;
        r.op   = op;
        r.cond = 4'hE;
        r.br   = off;
        return r;
    endfunction

    function automatic req_t mk_dt(input logic [10:0] op, input logic [3:0] rd,
                                   input logic [3:0] rn, input logic [11:0] off);
        req_t r;
        r      = '0;
        r.op   = op;
        r.cond = 4'hE;
        r.rd   = rd;
        r.rn   = rn;
        r.dt   = off;
        return r;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("err_illegal", 32'(err_illegal), 32'(exp_err));
            exp_err = 1'b0;
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_instr", out_instr, prev_instr);
                check("stall_addr", 32'(out_addr), 32'(prev_addr));
            end
            if (out_valid && !out_ready) check("stall_req_ready", 32'(req_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %h, expected no word", out_instr);
                end else begin
                    check("out_instr", out_instr, exp_q.pop_front());
                    check("out_addr", 32'(out_addr), 32'(model_addr % DEPTH));
                    model_addr++;
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_instr = out_instr;
            prev_addr  = out_addr;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_load();
        @(posedge clk);
        #1 start = 1'b1;
        model_addr = 0;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
    endtask

    task automatic send(input req_t r, input bit last, output int waits);
        logic [32:0] m;
        m             = model(r);
        req_op        = r.op;
        req_cond      = r.cond;
        req_rn        = r.rn;
        req_rd        = r.rd;
        req_rm        = r.rm;
        req_rotate    = r.rotate;
        req_s         = r.s;
        req_imm_en    = r.imm_en;
        req_shift     = r.shift;
        req_imm8      = r.imm8;
        req_br_offset = r.br;
        req_dt_offset = r.dt;
        req_last      = last;
        req_valid     = 1'b1;
        waits         = 0;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL req_ready_timeout: got 0 after %0d cycles, expected 1", waits);
            req_valid = 1'b0;
            req_last  = 1'b0;
            return;
        end
        if (m[32]) exp_q.push_back(m[31:0]);
        @(posedge clk);
        #1;
        exp_err   = !m[32];
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic finish_load(input bit exp_wrapped);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("done", 32'(done), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("wrapped", 32'(wrapped), 32'(exp_wrapped));
        check("words_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   w;
        int   total;
        req_t r;

        vectors     = 0;
        miscompares = 0;
        model_addr  = 0;
        exp_err     = 1'b0;
        stall_prev  = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        req_valid   = 1'b0;
        req_last    = 1'b0;
        req_op      = '0;
        req_cond    = '0;
        req_rn      = '0;
        req_rd      = '0;
        req_rm      = '0;
        req_rotate  = '0;
        req_s       = 1'b0;
        req_imm_en  = 1'b0;
        req_shift   = '0;
        req_imm8    = '0;
        req_br_offset = '0;
        req_dt_offset = '0;
        out_ready   = 1'b1;

        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_flags", {28'd0, err_illegal, busy, done, wrapped}, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Hand-computed words pin the model before it is trusted.
        check("pin_add", model(mk_dp(11'd0, 4'hE, 4'd5, 4'd7, 4'd6, 1'b0, 1'b0, 8'd0))[31:0], 32'hE0875006);
        check("pin_mov", model(mk_dp(11'd6, 4'hE, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 8'd0))[31:0], 32'hE1A00003);
        check("pin_addi", model(mk_dp(11'd0, 4'hE, 4'd4, 4'd4, 4'd0, 1'b0, 1'b1, 8'd1))[31:0], 32'hE2844001);
        check("pin_b", model(mk_br(11'd31, 24'd0))[31:0], 32'hEA000000);
        check("pin_cmp", model(mk_dp(11'd8, 4'hE, 4'd9, 4'd1, 4'd2, 1'b0, 1'b0, 8'd0))[31:0], 32'hE1510002);
        check("pin_ldr", model(mk_dt(11'd41, 4'd2, 4'd11, 12'd4))[31:0], 32'hE59B2004);
        check("pin_str", model(mk_dt(11'd42, 4'd2, 4'd11, 12'd4))[31:0], 32'hE58B2004);

        // Load 1: encoding vectors back to back; any bubble shows up as a wait.
        start_load();
        total = 0;
        send(mk_dp(11'd0, 4'hE, 4'd5, 4'd7, 4'd6, 1'b0, 1'b0, 8'd0), 1'b0, w); total += w;
        send(mk_dp(11'd6, 4'hE, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 8'd0), 1'b0, w); total += w;
        send(mk_dp(11'd0, 4'hE, 4'd4, 4'd4, 4'd0, 1'b0, 1'b1, 8'd1), 1'b0, w); total += w;
        send(mk_br(11'd31, 24'd0), 1'b0, w); total += w;
        send(mk_dp(11'd8, 4'hE, 4'd9, 4'd1, 4'd2, 1'b0, 1'b0, 8'd0), 1'b0, w); total += w;
        send(mk_dt(11'd41, 4'd2, 4'd11, 12'd4), 1'b0, w); total += w;
        send(mk_dt(11'd42, 4'd2, 4'd11, 12'd4), 1'b0, w); total += w;
        send(mk_br(11'd32, 24'h123456), 1'b0, w); total += w;
        send(mk_dp(11'd11, 4'h0, 4'd3, 4'd8, 4'd0, 1'b1, 1'b1, 8'hA5), 1'b0, w); total += w;
        send(mk_dp(11'd7, 4'hB, 4'd1, 4'd6, 4'd9, 1'b0, 1'b0, 8'd0), 1'b0, w); total += w;
        send(mk_dp(11'd10, 4'h1, 4'd7, 4'd2, 4'd4, 1'b0, 1'b0, 8'd0), 1'b1, w); total += w;
        check("stream_bubbles", 32'(total), 32'd0);
        finish_load(1'b1);

        // Load 2: illegal op between two ADDs; a stray start mid-load is ignored.
        start_load();
        send(mk_dp(11'd0, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 8'd0), 1'b0, w);
        start = 1'b1;
        send(mk_dp(11'd1, 4'hE, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 8'd0), 1'b0, w);
        start = 1'b0;
        send(mk_dp(11'd0, 4'hE, 4'd4, 4'd5, 4'd6, 1'b0, 1'b0, 8'd0), 1'b1, w);
        finish_load(1'b0);

        // Load 3: illegal op carrying req_last still ends the load.
        start_load();
        send(mk_dp(11'd2, 4'hE, 4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 8'd0), 1'b0, w);
        send(mk_dp(11'd99, 4'hE, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'd0), 1'b1, w);
        finish_load(1'b0);

        // Load 4: output stalled for three cycles mid-stream.
        start_load();
        total = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    r = mk_dp(11'd0, 4'hE, 4'(i), 4'(i + 1), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 8'd0);
                    send(r, i == 7, w);
                    total += w;
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("stall_waits", 32'(total), 32'd3);
        finish_load(1'b1);

        // Load 5: five words through a 2-bit address -> 0,1,2,3,0.
        start_load();
        for (int i = 0; i < 5; i++) begin
            send(mk_dp(11'd4, 4'hE, 4'(i), 4'd9, 4'(15 - i), 1'b0, 1'b0, 8'd0), i == 4, w);
        end
        finish_load(1'b1);

        // Load 6: reset while a word is held, then reload from address 0.
        start_load();
        out_ready = 1'b0;
        send(mk_dp(11'd5, 4'hE, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0, 8'd0), 1'b0, w);
        @(negedge clk);
        check("held_before_reset", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_instr", out_instr, 32'h0);
        check("mid_rst_out_addr", 32'(out_addr), 32'd0);
        check("mid_rst_flags", {28'd0, err_illegal, busy, done, wrapped}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        start_load();
        send(mk_dp(11'd6, 4'hE, 4'd8, 4'd0, 4'd2, 1'b0, 1'b0, 8'd0), 1'b1, w);
        finish_load(1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, width of the instruction-memory write address.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle pulse that opens a program load.
REQ-005 req_valid / req_ready  input / output  1 / 1  request handshake.
REQ-006 req_last  input  1  marks the final request of a load.
REQ-007 req_op  input  11  ALU control code: 0 ADD, 2 SUB, 3 AND, 4 ORR, 5 EOR, 6 MOV, 7 MVN, 8 CMP, 9 TST, 10 TEQ, 11 BIC, 31 B, 32 BL, 41 LDR, 42 STR.
REQ-008 req_cond, req_rn, req_rd, req_rm, req_rotate  input  4 each  instruction fields.
REQ-009 req_s, req_imm_en  input  1 each  set-flags bit and immediate-operand bit.
REQ-010 req_shift, req_imm8  input  8 each  shift field and 8-bit immediate.
REQ-011 req_br_offset  input  24  branch offset.
REQ-012 req_dt_offset  input  12  load/store offset.
REQ-013 out_valid / out_ready  output / input  1 / 1  write handshake.
REQ-014 out_instr  output  32  encoded instruction word.
REQ-015 out_addr  output  ADDR_W  write address for out_instr.
REQ-016 err_illegal  output  1  one-cycle pulse when an unsupported req_op is accepted.
REQ-017 busy / done  output  1 / 1  load in progress / load complete (sticky).
REQ-018 wrapped  output  1  sticky flag: the address counter passed its maximum value.

Function
REQ-019 The state machine SHALL have three states: IDLE, LOAD and DRAIN.
  - IDLE -> LOAD on start; address counter cleared to 0; done, wrapped and busy cleared.
  - LOAD -> DRAIN when a request with req_last=1 is accepted.
  - DRAIN -> IDLE once the output register is empty; done is set at that point.
REQ-020 req_ready SHALL equal (state==LOAD) && (!out_valid || out_ready).
REQ-021 Start SHALL be ignored outside IDLE.
REQ-022 A request SHALL be accepted on a cycle where req_valid && req_ready.
REQ-023 Latency SHALL be one cycle: out_instr and out_valid register on the accepting edge.
REQ-024 out_valid SHALL hold, with out_instr and out_addr stable, until out_ready.
REQ-025 Data-processing encoding SHALL be {cond, 2'b00, imm_en, opcode, S, rn, rd, op2}.
  - opcode: ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001, MOV 1101, MVN 1111, CMP 1010, TST 1000, TEQ 1001, BIC 1110.
  - op2 = imm_en ? {rotate, imm8} : {shift, rm}.
REQ-026 Data-processing field overrides:
  - CMP/TST/TEQ: S forced to 1, rd forced to 0.
  - MOV/MVN: rn forced to 0.
REQ-027 B/BL SHALL encode as {cond, 3'b101, L, br_offset}, with L=1 for BL.
REQ-028 LDR/STR SHALL encode as {cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, L, rn, rd, dt_offset}, with L=1 for LDR.
REQ-029 An unsupported req_op SHALL be consumed with no output, no address increment, and one err_illegal pulse.
  - If it carries req_last, the LOAD->DRAIN transition still occurs.
REQ-030 out_addr SHALL increment by 1 on each completed out handshake.
  - Wraps from 2^ADDR_W-1 to 0 and sets wrapped.
REQ-031 A simultaneous output handshake and new request acceptance SHALL be sustained at one instruction per cycle.

Reset
REQ-032 On rst_n low, asynchronously:
  - state = IDLE.
  - out_valid, err_illegal, busy, done, wrapped = 0.
  - out_addr = 0, out_instr = 32'h0.
REQ-033 Reset asserted mid-load SHALL discard any pending output word.

Structure
REQ-034 The shared package SHALL hold:
  - ALU control code constants.
  - Data-processing opcode constants.
  - Condition code constants.
  - The state enumeration.
REQ-035 The combinational field packing SHALL be one sub-module, instr_pack.
  - Inputs: request fields. Outputs: word and illegal flag.

Verification
REQ-036 The bench SHALL cover at least these directed scenarios:
  - Encode, cond=E: ADD rd=5 rn=7 rm=6 -> 0xE0875006; MOV rd=0 rm=3 -> 0xE1A00003; ADDI rd=4 rn=4 imm8=1 -> 0xE2844001; B offset 0 -> 0xEA000000.
  - CMP rn=1 rm=2 with req_s=0, req_rd=9 -> 0xE1510002; LDR rd=2 rn=11 off=4 -> 0xE59B2004; STR rd=2 rn=11 off=4 -> 0xE58B2004.
  - out_ready held low for 3 cycles during a stream -> out_instr/out_addr stable, req_ready=0, no word lost or duplicated; then 1 word/cycle.
  - req_op=1 between two ADDs -> err_illegal pulse; addresses 0 and 1 are the two ADDs.
  - ADDR_W=2, 5 words -> addresses 0,1,2,3,0; wrapped=1 after the fifth.
  - rst_n low while out_valid=1 in LOAD -> all outputs zero next sample; next start reloads from address 0.
